// File: rtl/regfile_mp_pkg.sv
// -----------------------------------------------------------------------------
// regfile_mp_pkg
// Shared definitions for the multi-port register file:
//   - state_t : clear sequencer states (IDLE, CLEAR)
//   - CC_N / CC_Z / CC_P : condition-code encodings for {N,Z,P}
//   - cc_encode() : maps sign/zero flags of a written value to a CC code
// Optional feature macro used by the register file: REGFILE_MP_BYPASS_EN
// -----------------------------------------------------------------------------
package regfile_mp_pkg;

   typedef enum logic [0:0] {
      IDLE  = 1'b0,
      CLEAR = 1'b1
   } state_t;

   localparam logic [2:0] CC_N = 3'b100;
   localparam logic [2:0] CC_Z = 3'b010;
   localparam logic [2:0] CC_P = 3'b001;

   // Negative wins over zero; a value cannot be both, so order only matters
   // for clarity.
   function automatic logic [2:0] cc_encode(input logic neg_s, input logic zero_s);
      logic [2:0] cc_s;
      if (neg_s) begin
         cc_s = CC_N;
      end else if (zero_s) begin
         cc_s = CC_Z;
      end else begin
         cc_s = CC_P;
      end
      return cc_s;
   endfunction

endpackage

// File: rtl/regfile_mp_clr_fsm.sv
// -----------------------------------------------------------------------------
// regfile_mp_clr_fsm
// Bulk-clear sequencer and write qualification for regfile_mp.
// Ports:
//   clk, rst_n   : clock, asynchronous active-low reset
//   ld_reg       : raw write request
//   clr_req      : bulk clear request (ignored while clearing)
//   wr_accept    : write may update the array this cycle (IDLE only)
//   clr_start    : IDLE->CLEAR transition happens at the coming edge
//   clr_en       : array entry clr_idx is zeroed at the coming edge
//   clr_idx      : index of the entry being cleared
//   clr_busy     : registered, high for exactly DEPTH cycles per clear
//   wr_drop      : registered one-cycle pulse after a write rejected in CLEAR
// -----------------------------------------------------------------------------
module regfile_mp_clr_fsm
   import regfile_mp_pkg::*;
#(
   parameter int DEPTH = 8,
   parameter int AW    = $clog2(DEPTH)
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          ld_reg,
   input  logic          clr_req,
   output logic          wr_accept,
   output logic          clr_start,
   output logic          clr_en,
   output logic [AW-1:0] clr_idx,
   output logic          clr_busy,
   output logic          wr_drop
);

   localparam logic [AW-1:0] LAST_IDX = AW'(DEPTH - 1);
   localparam logic [AW-1:0] ONE_IDX  = AW'(1);
   localparam logic [AW-1:0] ZERO_IDX = AW'(0);

   state_t state_r;

   // Decode the current state into per-cycle qualifiers for the array.
   always_comb begin
      wr_accept = 1'b0;
      clr_start = 1'b0;
      clr_en    = 1'b0;
      case (state_r)
         IDLE: begin
            wr_accept = ld_reg;
            clr_start = clr_req;
         end
         CLEAR: begin
            clr_en = 1'b1;
         end
         default: begin
            clr_en = 1'b0;
         end
      endcase
   end

   // Sequencer state, clear index, busy flag and dropped-write pulse.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r  <= IDLE;
         clr_idx  <= ZERO_IDX;
         clr_busy <= 1'b0;
         wr_drop  <= 1'b0;
      end else begin
         wr_drop <= ld_reg & (state_r == CLEAR);
         case (state_r)
            IDLE: begin
               if (clr_req) begin
                  state_r  <= CLEAR;
                  clr_idx  <= ZERO_IDX;
                  clr_busy <= 1'b1;
               end else begin
                  state_r  <= IDLE;
                  clr_busy <= 1'b0;
               end
            end
            CLEAR: begin
               // clr_req is deliberately not looked at here: no restart.
               if (clr_idx == LAST_IDX) begin
                  state_r  <= IDLE;
                  clr_idx  <= ZERO_IDX;
                  clr_busy <= 1'b0;
               end else begin
                  clr_idx  <= clr_idx + ONE_IDX;
                  clr_busy <= 1'b1;
               end
            end
            default: begin
               state_r  <= IDLE;
               clr_idx  <= ZERO_IDX;
               clr_busy <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: rtl/regfile_mp.sv
// -----------------------------------------------------------------------------
// regfile_mp
// Multi-read-port register file with condition codes and bulk clear.
// Parameters: WIDTH (data bits), DEPTH (entries, power of two >= 2),
//             NRD (read ports).
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   ld_reg, dr, data : write enable, write address, write data
//   ld_cc      : load cc_nzp from data on an accepted write
//   sr_addr    : packed read addresses, port i at [i*AW +: AW]
//   sr_data    : packed combinational read data, port i at [i*WIDTH +: WIDTH]
//   cc_nzp     : condition code register {N,Z,P}
//   clr_req    : start a DEPTH-cycle clear of all entries
//   clr_busy   : high while the clear runs
//   wr_drop    : one-cycle pulse after a write arrives during a clear
// Optional macro: REGFILE_MP_BYPASS_EN -- when defined, a read of the address
// being written in the same cycle returns the incoming data.
// -----------------------------------------------------------------------------
module regfile_mp
   import regfile_mp_pkg::*;
#(
   parameter  int WIDTH = 16,
   parameter  int DEPTH = 8,
   parameter  int NRD   = 2,
   localparam int AW    = $clog2(DEPTH)
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 ld_reg,
   input  logic [AW-1:0]        dr,
   input  logic [WIDTH-1:0]     data,
   input  logic                 ld_cc,
   input  logic [NRD*AW-1:0]    sr_addr,
   output logic [NRD*WIDTH-1:0] sr_data,
   output logic [2:0]           cc_nzp,
   input  logic                 clr_req,
   output logic                 clr_busy,
   output logic                 wr_drop
);

   logic [WIDTH-1:0] regs_r [DEPTH];
   logic [2:0]       cc_r;
   logic             wr_accept_s;
   logic             clr_start_s;
   logic             clr_en_s;
   logic [AW-1:0]    clr_idx_s;

   regfile_mp_clr_fsm #(
      .DEPTH (DEPTH),
      .AW    (AW)
   ) u_clr_fsm (
      .clk       (clk),
      .rst_n     (rst_n),
      .ld_reg    (ld_reg),
      .clr_req   (clr_req),
      .wr_accept (wr_accept_s),
      .clr_start (clr_start_s),
      .clr_en    (clr_en_s),
      .clr_idx   (clr_idx_s),
      .clr_busy  (clr_busy),
      .wr_drop   (wr_drop)
   );

   // Storage array: clear sweep and accepted writes are mutually exclusive
   // because writes are only accepted outside the clear.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < DEPTH; i++) begin
            regs_r[i] <= {WIDTH{1'b0}};
         end
      end else if (clr_en_s) begin
         regs_r[clr_idx_s] <= {WIDTH{1'b0}};
      end else if (wr_accept_s) begin
         regs_r[dr] <= data;
      end else begin
         regs_r[dr] <= regs_r[dr];
      end
   end

   // Condition codes: entering a clear forces Z, even when a write with
   // ld_cc is accepted on that same edge.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cc_r <= CC_Z;
      end else if (clr_start_s) begin
         cc_r <= CC_Z;
      end else if (wr_accept_s && ld_cc) begin
         cc_r <= cc_encode(data[WIDTH-1], data == {WIDTH{1'b0}});
      end else begin
         cc_r <= cc_r;
      end
   end

   assign cc_nzp = cc_r;

   // Independent combinational read ports.
   always_comb begin
      sr_data = {(NRD*WIDTH){1'b0}};
      for (int i = 0; i < NRD; i++) begin
`ifdef REGFILE_MP_BYPASS_EN
         if (wr_accept_s && (sr_addr[i*AW +: AW] == dr)) begin
            sr_data[i*WIDTH +: WIDTH] = data;
         end else begin
            sr_data[i*WIDTH +: WIDTH] = regs_r[sr_addr[i*AW +: AW]];
         end
`else
         sr_data[i*WIDTH +: WIDTH] = regs_r[sr_addr[i*AW +: AW]];
`endif
      end
   end

endmodule

// File: tb/tb_regfile_mp.sv
// -----------------------------------------------------------------------------
// tb_regfile_mp
// Self-checking bench for regfile_mp (default parameters, 2 read ports).
// A behavioural model tracks array contents, condition codes and the clear
// progress; every cycle the DUT outputs are compared against it, plus
// table-driven directed vectors and hand-written clear/reset sequences.
// -----------------------------------------------------------------------------
module tb_regfile_mp;

   localparam int W  = 16;
   localparam int D  = 8;
   localparam int AW = 3;

   logic            clk = 1'b0;
   logic            rst_n;
   logic            ld_reg;
   logic [AW-1:0]   dr;
   logic [W-1:0]    data;
   logic            ld_cc;
   logic [2*AW-1:0] sr_addr;
   logic [2*W-1:0]  sr_data;
   logic [2:0]      cc_nzp;
   logic            clr_req;
   logic            clr_busy;
   logic            wr_drop;
   logic [AW-1:0]   a0;
   logic [AW-1:0]   a1;

   assign sr_addr = {a1, a0};

   always #5 clk = ~clk;

   regfile_mp dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .ld_reg   (ld_reg),
      .dr       (dr),
      .data     (data),
      .ld_cc    (ld_cc),
      .sr_addr  (sr_addr),
      .sr_data  (sr_data),
      .cc_nzp   (cc_nzp),
      .clr_req  (clr_req),
      .clr_busy (clr_busy),
      .wr_drop  (wr_drop)
   );

   // ---------------- reference model ----------------
   logic [W-1:0] m_mem [D];
   bit           m_busy;
   int           m_idx;
   bit           m_drop;
   logic [2:0]   m_cc;

   int checks = 0;
   int errors = 0;

   function automatic logic [2:0] ref_cc(input logic [W-1:0] v);
      if ($signed(v) < 0) return 3'b100;
      else if (v == 16'd0) return 3'b010;
      else return 3'b001;
   endfunction

   task automatic model_reset();
      for (int i = 0; i < D; i++) m_mem[i] = 16'd0;
      m_busy = 1'b0;
      m_idx  = 0;
      m_drop = 1'b0;
      m_cc   = 3'b010;
   endtask

   // Apply one rising edge to the model using the currently driven inputs.
   task automatic model_edge();
      bit nxt_drop;
      nxt_drop = ld_reg && m_busy;
      if (m_busy) begin
         m_mem[m_idx] = 16'd0;
         m_idx = m_idx + 1;
         if (m_idx == D) begin
            m_busy = 1'b0;
            m_idx  = 0;
         end
      end else begin
         if (ld_reg) m_mem[dr] = data;
         if (clr_req) begin
            m_busy = 1'b1;
            m_idx  = 0;
            m_cc   = 3'b010;
         end else if (ld_reg && ld_cc) begin
            m_cc = ref_cc(data);
         end
      end
      m_drop = nxt_drop;
   endtask

   function automatic logic [W-1:0] exp_read(input logic [AW-1:0] a);
      logic [W-1:0] e;
      e = m_mem[a];
`ifdef REGFILE_MP_BYPASS_EN
      if (ld_reg && !m_busy && (a == dr)) e = data;
`endif
      return e;
   endfunction

   task automatic chk(input string name, input logic [W-1:0] got, input logic [W-1:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
      end
   endtask

   task automatic check_all(input string tag);
      chk({tag, "/rd0"},  sr_data[W-1:0],   exp_read(a0));
      chk({tag, "/rd1"},  sr_data[2*W-1:W], exp_read(a1));
      chk({tag, "/cc"},   {13'd0, cc_nzp},  {13'd0, m_cc});
      chk({tag, "/busy"}, {15'd0, clr_busy}, {15'd0, m_busy});
      chk({tag, "/drop"}, {15'd0, wr_drop}, {15'd0, m_drop});
   endtask

   // Called with clk low and inputs already driven: check, clock, advance model.
   task automatic cycle(input string tag);
      #1 check_all(tag);
      @(posedge clk);
      model_edge();
      @(negedge clk);
   endtask

   typedef struct {
      logic          wr;
      logic [AW-1:0] wdr;
      logic [W-1:0]  wd;
      logic          lc;
      logic [AW-1:0] ra0;
      logic [AW-1:0] ra1;
      logic [W-1:0]  e0;
      logic [W-1:0]  e1;
      logic [2:0]    ecc;
   } vec_t;

   vec_t tv [6];
   int   nb;

   initial begin
      // Directed vectors: apply a write, then read back with ld_reg low.
      tv[0] = '{1'b1, 3'd3, 16'h0069, 1'b1, 3'd3, 3'd0, 16'h0069, 16'h0000, 3'b001};
      tv[1] = '{1'b1, 3'd5, 16'h8000, 1'b1, 3'd5, 3'd3, 16'h8000, 16'h0069, 3'b100};
      tv[2] = '{1'b1, 3'd6, 16'h0000, 1'b1, 3'd5, 3'd6, 16'h8000, 16'h0000, 3'b010};
      tv[3] = '{1'b1, 3'd7, 16'h7FFF, 1'b0, 3'd7, 3'd7, 16'h7FFF, 16'h7FFF, 3'b010};
      tv[4] = '{1'b0, 3'd1, 16'h8001, 1'b1, 3'd1, 3'd7, 16'h0000, 16'h7FFF, 3'b010};
      tv[5] = '{1'b1, 3'd1, 16'hFFFF, 1'b1, 3'd1, 3'd6, 16'hFFFF, 16'h0000, 3'b100};

      rst_n = 1'b0; ld_reg = 1'b0; ld_cc = 1'b0; clr_req = 1'b0;
      dr = 3'd0; data = 16'd0; a0 = 3'd0; a1 = 3'd7;
      model_reset();
      @(negedge clk);
      @(negedge clk);
      #1 check_all("reset");
      rst_n = 1'b1;

      // Table-driven directed writes and condition codes.
      for (int i = 0; i < 6; i++) begin
         ld_reg = tv[i].wr; dr = tv[i].wdr; data = tv[i].wd; ld_cc = tv[i].lc;
         a0 = tv[i].ra0; a1 = tv[i].ra1;
         cycle("table_wr");
         ld_reg = 1'b0; ld_cc = 1'b0;
         #1;
         chk("table_rd0", sr_data[W-1:0],   tv[i].e0);
         chk("table_rd1", sr_data[2*W-1:W], tv[i].e1);
         chk("table_cc",  {13'd0, cc_nzp},  {13'd0, tv[i].ecc});
      end

      // Same-cycle read of the address being written.
      ld_reg = 1'b1; dr = 3'd4; data = 16'h0042; ld_cc = 1'b0; a0 = 3'd4; a1 = 3'd3;
      #1;
`ifdef REGFILE_MP_BYPASS_EN
      chk("bypass_same_cycle", sr_data[W-1:0], 16'h0042);
`else
      chk("bypass_same_cycle", sr_data[W-1:0], 16'h0000);
`endif
      cycle("bypass_wr");
      ld_reg = 1'b0;
      #1 chk("bypass_after", sr_data[W-1:0], 16'h0042);

      // Fill, then clear with a dropped write and a second clr_req mid-clear.
      for (int k = 0; k < D; k++) begin
         ld_reg = 1'b1; dr = 3'(k); data = 16'hA5A5; a0 = 3'(k); a1 = 3'(k);
         cycle("fill");
      end
      ld_reg = 1'b0; clr_req = 1'b1; a0 = 3'd0; a1 = 3'd7;
      cycle("clr_start");
      clr_req = 1'b0;
      #1;
      chk("clr_cc", {13'd0, cc_nzp}, 16'h0002);
      nb = 0;
      for (int k = 0; k < 20; k++) begin
         if (!clr_busy) break;
         nb++;
         a0 = 3'(k); a1 = 3'(k - 1);
         if (k == 2) begin
            ld_reg = 1'b1; dr = 3'd2; data = 16'h1234; clr_req = 1'b1;
         end else begin
            ld_reg = 1'b0; clr_req = 1'b0;
         end
         if (k == 3) chk("drop_pulse", {15'd0, wr_drop}, 16'h0001);
         if (k == 4) chk("drop_end",   {15'd0, wr_drop}, 16'h0000);
         cycle("clearing");
      end
      ld_reg = 1'b0; clr_req = 1'b0;
      chk("clr_busy_len", 16'(nb), 16'd8);
      for (int k = 0; k < D; k++) begin
         a0 = 3'(k); a1 = 3'(D - 1 - k);
         #1 chk("clr_zero", sr_data[W-1:0], 16'h0000);
      end
      cycle("post_clr");

      // Reset in the middle of a clear.
      for (int k = 0; k < D; k++) begin
         ld_reg = 1'b1; dr = 3'(k); data = 16'h5A5A; a0 = 3'(k); a1 = 3'(k);
         cycle("fill2");
      end
      ld_reg = 1'b0; clr_req = 1'b1;
      cycle("clr2_start");
      clr_req = 1'b0;
      for (int k = 0; k < 3; k++) cycle("clr2_run");
      rst_n = 1'b0;
      model_reset();
      #1;
      chk("rst_busy", {15'd0, clr_busy}, 16'h0000);
      chk("rst_cc",   {13'd0, cc_nzp},   16'h0002);
      for (int k = 0; k < D; k++) begin
         a0 = 3'(k); a1 = 3'(D - 1 - k);
         #1 check_all("rst_mid");
      end
      @(negedge clk);
      rst_n = 1'b1;
      ld_reg = 1'b1; dr = 3'd6; data = 16'h0777; ld_cc = 1'b1; a0 = 3'd6; a1 = 3'd5;
      cycle("first_edge");
      ld_reg = 1'b0; ld_cc = 1'b0;
      for (int k = 0; k < 10; k++) cycle("after_rst");
      chk("first_edge_wr", sr_data[W-1:0], 16'h0777);

      // Randomized traffic against the model.
      for (int n = 0; n < 400; n++) begin
         ld_reg  = 1'($urandom_range(0, 1));
         dr      = 3'($urandom_range(0, 7));
         case ($urandom_range(0, 3))
            0: data = 16'h0000;
            1: data = 16'h8000 | 16'($urandom_range(0, 255));
            default: data = 16'($urandom);
         endcase
         ld_cc   = 1'($urandom_range(0, 1));
         clr_req = ($urandom_range(0, 15) == 0);
         a0      = 3'($urandom_range(0, 7));
         a1      = ($urandom_range(0, 3) == 0) ? dr : 3'($urandom_range(0, 7));
         cycle("rand");
      end
      ld_reg = 1'b0; clr_req = 1'b0;
      #1 check_all("final");

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
